// File: rtl/sky130_fd_io__pwr_seq_pkg.sv
// ---------------------------------------------------------------------------
// sky130_fd_io__pwr_seq_pkg
// Shared definitions for the pad-ring power sequencer:
//   - pwr_state_t  : sequencer state encodings (also exported on STATE)
//   - fault_code_t : cause codes exported on FAULT_CODE
//   - TIMER_W      : width of the shared wait/settle timer
//   - timer_runs() : which states advance the shared timer
// ---------------------------------------------------------------------------
package sky130_fd_io__pwr_seq_pkg;

  localparam int TIMER_W = 10;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_W_IO    = 3'd1,
    ST_W_CORE  = 3'd2,
    ST_W_ANA   = 3'd3,
    ST_SETTLE  = 3'd4,
    ST_READY   = 3'd5,
    ST_FAULT   = 3'd6,
    ST_ILLEGAL = 3'd7
  } pwr_state_t;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_TIMEOUT   = 2'd1,
    FC_DROP_RUN  = 2'd2,
    FC_DROP_WAIT = 2'd3
  } fault_code_t;

  // The timer only counts while waiting on a rail or settling; everywhere
  // else it is held at zero.
  function automatic logic timer_runs(input pwr_state_t s);
    return (s == ST_W_IO) || (s == ST_W_CORE) || (s == ST_W_ANA) ||
           (s == ST_SETTLE);
  endfunction

endpackage

// File: rtl/sky130_fd_io__pwrgood_deb.sv
// ---------------------------------------------------------------------------
// sky130_fd_io__pwrgood_deb
// Qualifies one asynchronous rail-good indicator: 2-flop synchronizer
// followed by a saturating debounce counter (slow rise, fast drop).
// Ports:
//   clk      in  1  always-on clock
//   rst      in  1  synchronous active-high reset
//   raw_good in  1  raw analog detector output (asynchronous)
//   ok       out 1  rail qualified as good
// ---------------------------------------------------------------------------
module sky130_fd_io__pwrgood_deb #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_good,
  output logic ok
);

  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYC);

  logic       meta;
  logic       sync;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      cnt  <= '0;
    end else begin
      meta <= raw_good;
      sync <= meta;
      if (!sync) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Gating with the synchronized level makes a drop visible in the same
  // cycle the low value leaves the synchronizer, ahead of the counter clear.
  assign ok = sync && (cnt == CNT_MAX);

endmodule

// File: rtl/sky130_fd_io__pwr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sky130_fd_io__pwr_seq_ctrl
// Turns per-rail good indicators into an ordered enable sequence
// (VDDIO -> VCCD -> VDDA -> settle), then releases I/O hold and flags
// power-ready. Timeouts and rail drops latch a fault until cleared.
// Ports:
//   CLK        in  1  always-on clock
//   RST        in  1  synchronous active-high reset
//   PWR_REQ    in  1  level power-up request (0 = power down)
//   FAULT_CLR  in  1  fault clear (honoured only with PWR_REQ = 0)
//   VDDIO_GOOD in  1  raw VDDIO good (async)
//   VCCD_GOOD  in  1  raw VCCD good (async)
//   VDDA_GOOD  in  1  raw VDDA good (async)
//   IO_EN      out 1  VDDIO switch enable
//   CORE_EN    out 1  VCCD switch enable
//   ANA_EN     out 1  VDDA switch enable
//   HOLD_REL   out 1  I/O isolation hold release
//   PWR_READY  out 1  all rails up and settled
//   FAULT      out 1  latched fault
//   FAULT_CODE out 2  fault cause
//   STATE      out 3  current state (debug)
// ---------------------------------------------------------------------------
module sky130_fd_io__pwr_seq_ctrl
  import sky130_fd_io__pwr_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int SETTLE_CYC   = 64,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PWR_REQ,
  input  logic       FAULT_CLR,
  input  logic       VDDIO_GOOD,
  input  logic       VCCD_GOOD,
  input  logic       VDDA_GOOD,
  output logic       IO_EN,
  output logic       CORE_EN,
  output logic       ANA_EN,
  output logic       HOLD_REL,
  output logic       PWR_READY,
  output logic       FAULT,
  output logic [1:0] FAULT_CODE,
  output logic [2:0] STATE
);

  localparam logic [TIMER_W-1:0] SETTLE_LAST  = TIMER_W'(SETTLE_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC - 1);

  logic               vddio_ok;
  logic               vccd_ok;
  logic               vdda_ok;
  logic               all_ok;
  logic               settle_done;
  logic               timeout_hit;
  logic [TIMER_W-1:0] timer;
  pwr_state_t         state;
  pwr_state_t         next_state;
  fault_code_t        code;
  fault_code_t        next_code;

  sky130_fd_io__pwrgood_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_vddio (
    .clk      (CLK),
    .rst      (RST),
    .raw_good (VDDIO_GOOD),
    .ok       (vddio_ok)
  );

  sky130_fd_io__pwrgood_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_vccd (
    .clk      (CLK),
    .rst      (RST),
    .raw_good (VCCD_GOOD),
    .ok       (vccd_ok)
  );

  sky130_fd_io__pwrgood_deb #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_vdda (
    .clk      (CLK),
    .rst      (RST),
    .raw_good (VDDA_GOOD),
    .ok       (vdda_ok)
  );

  assign all_ok      = vddio_ok && vccd_ok && vdda_ok;
  assign settle_done = (timer == SETTLE_LAST);
  assign timeout_hit = (timer == TIMEOUT_LAST);

  // Next-state logic. Inside each running state the checks are ordered
  // power-down, rail drop, progression, timeout; a timeout only counts when
  // the awaited rail is still not ok, so progression may precede it.
  always_comb begin
    next_state = state;
    next_code  = code;
    case (state)
      ST_OFF: begin
        if (PWR_REQ) next_state = ST_W_IO;
      end
      ST_W_IO: begin
        if (!PWR_REQ) begin
          next_state = ST_OFF;
          next_code  = FC_NONE;
        end else if (vddio_ok) begin
          next_state = ST_W_CORE;
        end else if (timeout_hit) begin
          next_state = ST_FAULT;
          next_code  = FC_TIMEOUT;
        end
      end
      ST_W_CORE: begin
        if (!PWR_REQ) begin
          next_state = ST_OFF;
          next_code  = FC_NONE;
        end else if (!vddio_ok) begin
          next_state = ST_FAULT;
          next_code  = FC_DROP_WAIT;
        end else if (vccd_ok) begin
          next_state = ST_W_ANA;
        end else if (timeout_hit) begin
          next_state = ST_FAULT;
          next_code  = FC_TIMEOUT;
        end
      end
      ST_W_ANA: begin
        if (!PWR_REQ) begin
          next_state = ST_OFF;
          next_code  = FC_NONE;
        end else if (!(vddio_ok && vccd_ok)) begin
          next_state = ST_FAULT;
          next_code  = FC_DROP_WAIT;
        end else if (vdda_ok) begin
          next_state = ST_SETTLE;
        end else if (timeout_hit) begin
          next_state = ST_FAULT;
          next_code  = FC_TIMEOUT;
        end
      end
      ST_SETTLE: begin
        if (!PWR_REQ) begin
          next_state = ST_OFF;
          next_code  = FC_NONE;
        end else if (!all_ok) begin
          next_state = ST_FAULT;
          next_code  = FC_DROP_RUN;
        end else if (settle_done) begin
          next_state = ST_READY;
        end
      end
      ST_READY: begin
        if (!PWR_REQ) begin
          next_state = ST_OFF;
          next_code  = FC_NONE;
        end else if (!all_ok) begin
          next_state = ST_FAULT;
          next_code  = FC_DROP_RUN;
        end
      end
      ST_FAULT: begin
        // Software must drop the request before the clear is honoured, so a
        // still-asserted request cannot restart straight out of a fault.
        if (FAULT_CLR && !PWR_REQ) begin
          next_state = ST_OFF;
          next_code  = FC_NONE;
        end
      end
      default: begin
        next_state = ST_OFF;
        next_code  = FC_NONE;
      end
    endcase
  end

  // State, fault code, timer and output registers. Outputs are decoded from
  // the next state so they change on the same edge as the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_OFF;
      code      <= FC_NONE;
      timer     <= '0;
      IO_EN     <= 1'b0;
      CORE_EN   <= 1'b0;
      ANA_EN    <= 1'b0;
      HOLD_REL  <= 1'b0;
      PWR_READY <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      state <= next_state;
      code  <= next_code;
      if ((next_state != state) || !timer_runs(state)) begin
        timer <= '0;
      end else begin
        timer <= timer + TIMER_W'(1);
      end
      IO_EN     <= next_state inside {ST_W_IO, ST_W_CORE, ST_W_ANA,
                                      ST_SETTLE, ST_READY};
      CORE_EN   <= next_state inside {ST_W_CORE, ST_W_ANA, ST_SETTLE,
                                      ST_READY};
      ANA_EN    <= next_state inside {ST_W_ANA, ST_SETTLE, ST_READY};
      HOLD_REL  <= (next_state == ST_READY);
      PWR_READY <= (next_state == ST_READY);
      FAULT     <= (next_state == ST_FAULT);
    end
  end

  assign STATE      = state;
  assign FAULT_CODE = code;

endmodule

// File: tb/tb_sky130_fd_io__pwr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sky130_fd_io__pwr_seq_ctrl
// Directed self-checking bench for the pad-ring power sequencer. Inputs are
// driven and outputs observed 1 time unit after each rising clock edge.
// Edge numbers in comments count rising edges after reset release.
// ---------------------------------------------------------------------------
module tb_sky130_fd_io__pwr_seq_ctrl;

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_W_IO   = 3'd1;
  localparam logic [2:0] S_W_CORE = 3'd2;
  localparam logic [2:0] S_W_ANA  = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_READY  = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PWR_REQ = 1'b0;
  logic        FAULT_CLR = 1'b0;
  logic        VDDIO_GOOD = 1'b0;
  logic        VCCD_GOOD = 1'b0;
  logic        VDDA_GOOD = 1'b0;
  logic        IO_EN;
  logic        CORE_EN;
  logic        ANA_EN;
  logic        HOLD_REL;
  logic        PWR_READY;
  logic        FAULT;
  logic [1:0]  FAULT_CODE;
  logic [2:0]  STATE;
  logic [10:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  sky130_fd_io__pwr_seq_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .PWR_REQ    (PWR_REQ),
    .FAULT_CLR  (FAULT_CLR),
    .VDDIO_GOOD (VDDIO_GOOD),
    .VCCD_GOOD  (VCCD_GOOD),
    .VDDA_GOOD  (VDDA_GOOD),
    .IO_EN      (IO_EN),
    .CORE_EN    (CORE_EN),
    .ANA_EN     (ANA_EN),
    .HOLD_REL   (HOLD_REL),
    .PWR_READY  (PWR_READY),
    .FAULT      (FAULT),
    .FAULT_CODE (FAULT_CODE),
    .STATE      (STATE)
  );

  assign outs = {IO_EN, CORE_EN, ANA_EN, HOLD_REL, PWR_READY, FAULT,
                 FAULT_CODE, STATE};

  // Expected output vector for a given state and fault code, written from
  // the enable table: {IO,CORE,ANA,HOLD_REL,PWR_READY,FAULT,CODE,STATE}.
  function automatic logic [10:0] exp_outs(input logic [2:0] st,
                                           input logic [1:0] fc);
    logic io, core, ana, rdy, flt;
    io   = (st >= S_W_IO)   && (st <= S_READY);
    core = (st >= S_W_CORE) && (st <= S_READY);
    ana  = (st >= S_W_ANA)  && (st <= S_READY);
    rdy  = (st == S_READY);
    flt  = (st == S_FAULT);
    return {io, core, ana, rdy, rdy, flt, fc, st};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic apply_reset(input logic req, input logic io,
                             input logic core, input logic ana);
    RST        = 1'b1;
    PWR_REQ    = req;
    FAULT_CLR  = 1'b0;
    VDDIO_GOOD = io;
    VCCD_GOOD  = core;
    VDDA_GOOD  = ana;
    tick(2);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(1);
    n_checks++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_first_edge: got %b required %b", outs, 11'd0);
    end
    tick(1);
    n_checks++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_second_edge: got %b required %b", outs, 11'd0);
    end
    RST = 1'b0;
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_OFF, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL reset_idle_off: got %b required %b", outs, exp_outs(S_OFF, 2'd0));
    end
  endtask

  task automatic test_nominal();
    apply_reset(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1);   // edge 1
    n_checks++;
    if (outs !== exp_outs(S_W_IO, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL nominal_enter_w_io: got %b required %b", outs, exp_outs(S_W_IO, 2'd0));
    end
    tick(17);  // edge 18: debounce completes at this edge
    n_checks++;
    if (outs !== exp_outs(S_W_IO, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL nominal_w_io_held: got %b required %b", outs, exp_outs(S_W_IO, 2'd0));
    end
    tick(1);   // edge 19
    n_checks++;
    if (outs !== exp_outs(S_W_CORE, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL nominal_w_core: got %b required %b", outs, exp_outs(S_W_CORE, 2'd0));
    end
    tick(1);   // edge 20
    n_checks++;
    if (outs !== exp_outs(S_W_ANA, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL nominal_w_ana: got %b required %b", outs, exp_outs(S_W_ANA, 2'd0));
    end
    tick(1);   // edge 21
    n_checks++;
    if (outs !== exp_outs(S_SETTLE, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL nominal_settle: got %b required %b", outs, exp_outs(S_SETTLE, 2'd0));
    end
    tick(63);  // edge 84: last SETTLE cycle
    n_checks++;
    if (outs !== exp_outs(S_SETTLE, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL nominal_settle_last: got %b required %b", outs, exp_outs(S_SETTLE, 2'd0));
    end
    tick(1);   // edge 85
    n_checks++;
    if (outs !== exp_outs(S_READY, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL nominal_ready: got %b required %b", outs, exp_outs(S_READY, 2'd0));
    end
  endtask

  task automatic test_precedence_and_reset();
    apply_reset(1'b1, 1'b1, 1'b1, 1'b1);
    tick(84);  // edge 84: SETTLE expires on the next edge
    PWR_REQ = 1'b0;
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_OFF, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL prec_settle_vs_pwrdown: got %b required %b", outs, exp_outs(S_OFF, 2'd0));
    end
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_OFF, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL prec_stay_off: got %b required %b", outs, exp_outs(S_OFF, 2'd0));
    end
    // Rails are still qualified, so each wait state lasts one cycle.
    PWR_REQ = 1'b1;
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_W_IO, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL fast_w_io: got %b required %b", outs, exp_outs(S_W_IO, 2'd0));
    end
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_W_CORE, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL fast_w_core: got %b required %b", outs, exp_outs(S_W_CORE, 2'd0));
    end
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_W_ANA, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL fast_w_ana: got %b required %b", outs, exp_outs(S_W_ANA, 2'd0));
    end
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_SETTLE, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL fast_settle: got %b required %b", outs, exp_outs(S_SETTLE, 2'd0));
    end
    tick(64);
    n_checks++;
    if (outs !== exp_outs(S_READY, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL fast_ready: got %b required %b", outs, exp_outs(S_READY, 2'd0));
    end
    RST = 1'b1;
    tick(1);
    n_checks++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_ready: got %b required %b", outs, 11'd0);
    end
    RST = 1'b0;
    PWR_REQ = 1'b0;
    tick(1);
  endtask

  task automatic test_ordered_rails();
    apply_reset(1'b1, 1'b1, 1'b0, 1'b1);
    tick(19);  // edge 19
    n_checks++;
    if (outs !== exp_outs(S_W_CORE, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL ordered_enter_w_core: got %b required %b", outs, exp_outs(S_W_CORE, 2'd0));
    end
    for (int c = 20; c <= 100; c++) begin
      tick(1);
      n_checks++;
      if (outs !== exp_outs(S_W_CORE, 2'd0)) begin
        n_fail++;
        $display("[TB] FAIL ordered_w_core_edge%0d: got %b required %b", c, outs, exp_outs(S_W_CORE, 2'd0));
      end
    end
    VCCD_GOOD = 1'b1;  // raw rise after edge 100; ok after edge 118
    for (int c = 101; c <= 118; c++) begin
      tick(1);
      n_checks++;
      if (outs !== exp_outs(S_W_CORE, 2'd0)) begin
        n_fail++;
        $display("[TB] FAIL ordered_debounce_edge%0d: got %b required %b", c, outs, exp_outs(S_W_CORE, 2'd0));
      end
    end
    tick(1);   // edge 119
    n_checks++;
    if (outs !== exp_outs(S_W_ANA, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL ordered_w_ana: got %b required %b", outs, exp_outs(S_W_ANA, 2'd0));
    end
    tick(1);   // edge 120
    n_checks++;
    if (outs !== exp_outs(S_SETTLE, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL ordered_settle: got %b required %b", outs, exp_outs(S_SETTLE, 2'd0));
    end
    PWR_REQ = 1'b0;
    tick(1);
  endtask

  task automatic test_timeout();
    apply_reset(1'b1, 1'b1, 1'b1, 1'b0);
    tick(20);  // edge 20: enter W_ANA
    n_checks++;
    if (outs !== exp_outs(S_W_ANA, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL timeout_enter_w_ana: got %b required %b", outs, exp_outs(S_W_ANA, 2'd0));
    end
    tick(999); // edge 1019: 1000th cycle in W_ANA
    n_checks++;
    if (outs !== exp_outs(S_W_ANA, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL timeout_not_early: got %b required %b", outs, exp_outs(S_W_ANA, 2'd0));
    end
    tick(1);   // edge 1020
    n_checks++;
    if (outs !== exp_outs(S_FAULT, 2'd1)) begin
      n_fail++;
      $display("[TB] FAIL timeout_fault: got %b required %b", outs, exp_outs(S_FAULT, 2'd1));
    end
    FAULT_CLR = 1'b1;
    tick(2);
    n_checks++;
    if (outs !== exp_outs(S_FAULT, 2'd1)) begin
      n_fail++;
      $display("[TB] FAIL clr_with_req_ignored: got %b required %b", outs, exp_outs(S_FAULT, 2'd1));
    end
    FAULT_CLR = 1'b0;
    PWR_REQ = 1'b0;
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_FAULT, 2'd1)) begin
      n_fail++;
      $display("[TB] FAIL fault_held_no_clr: got %b required %b", outs, exp_outs(S_FAULT, 2'd1));
    end
    FAULT_CLR = 1'b1;
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_OFF, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL fault_cleared: got %b required %b", outs, exp_outs(S_OFF, 2'd0));
    end
    FAULT_CLR = 1'b0;
  endtask

  task automatic test_wait_drop();
    // VDDIO and VCCD remain qualified from the previous scenario.
    PWR_REQ = 1'b1;
    tick(3);   // W_IO, W_CORE, W_ANA
    n_checks++;
    if (outs !== exp_outs(S_W_ANA, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL wdrop_w_ana: got %b required %b", outs, exp_outs(S_W_ANA, 2'd0));
    end
    VCCD_GOOD = 1'b0;
    tick(1);
    VCCD_GOOD = 1'b1;
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_W_ANA, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL wdrop_sync_delay: got %b required %b", outs, exp_outs(S_W_ANA, 2'd0));
    end
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_FAULT, 2'd3)) begin
      n_fail++;
      $display("[TB] FAIL wdrop_fault: got %b required %b", outs, exp_outs(S_FAULT, 2'd3));
    end
    PWR_REQ = 1'b0;
    FAULT_CLR = 1'b1;
    tick(1);
    FAULT_CLR = 1'b0;
  endtask

  task automatic test_ready_drop();
    apply_reset(1'b1, 1'b1, 1'b1, 1'b1);
    tick(85);
    n_checks++;
    if (outs !== exp_outs(S_READY, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL rdrop_ready: got %b required %b", outs, exp_outs(S_READY, 2'd0));
    end
    VCCD_GOOD = 1'b0;
    tick(1);
    VCCD_GOOD = 1'b1;
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_READY, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL rdrop_sync_delay: got %b required %b", outs, exp_outs(S_READY, 2'd0));
    end
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_FAULT, 2'd2)) begin
      n_fail++;
      $display("[TB] FAIL rdrop_fault: got %b required %b", outs, exp_outs(S_FAULT, 2'd2));
    end
    PWR_REQ = 1'b0;
    FAULT_CLR = 1'b1;
    tick(1);
    FAULT_CLR = 1'b0;
  endtask

  task automatic test_glitch();
    apply_reset(1'b1, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 20; p++) begin
      VDDIO_GOOD = 1'b1;
      for (int h = 0; h < 10; h++) begin
        tick(1);
        n_checks++;
        if (outs !== exp_outs(S_W_IO, 2'd0)) begin
          n_fail++;
          $display("[TB] FAIL glitch_p%0d_h%0d: got %b required %b", p, h, outs, exp_outs(S_W_IO, 2'd0));
        end
      end
      VDDIO_GOOD = 1'b0;
      tick(1);
      n_checks++;
      if (outs !== exp_outs(S_W_IO, 2'd0)) begin
        n_fail++;
        $display("[TB] FAIL glitch_p%0d_low: got %b required %b", p, outs, exp_outs(S_W_IO, 2'd0));
      end
    end
    PWR_REQ = 1'b0;
    tick(1);
    n_checks++;
    if (outs !== exp_outs(S_OFF, 2'd0)) begin
      n_fail++;
      $display("[TB] FAIL pwrdown_from_w_io: got %b required %b", outs, exp_outs(S_OFF, 2'd0));
    end
  endtask

  initial begin
    $display("[TB] starting sky130_fd_io__pwr_seq_ctrl bench");
    test_reset();
    test_nominal();
    test_precedence_and_reset();
    test_ordered_rails();
    test_timeout();
    test_wait_drop();
    test_ready_drop();
    test_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
